clk_div_bank: RTL and testbench

Parametrised, fully synchronous multi-channel clock-enable generator. Replaces the ripple-flop divider chain: every channel runs on the single system clock, with a runtime-programmable divisor and output mode. Each channel produces a registered divided square wave and a one-cycle tick for downstream logic. Divisor updates are glitch-free, taking effect only at a period boundary.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_chan.sv | 101 ++++++++++
 rtl/clk_div_bank.sv | 60 ++++++
 tb/tb_clk_div_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable divider bank.
package clk_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned MaxCw = 32;

  // Divisor is held at the widest legal width; channels use the low CW bits.
  typedef struct packed {
    logic [MaxCw-1:0] div;
    mode_e            mode;
  } chan_cfg_t;

  function automatic int unsigned ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, deferred-config register and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          sync_all,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_div,
  input  logic          wr_mode,
  output logic          div_out,
  output logic          tick,
  output logic          active,
  output logic          pending
);

  localparam logic [CW-1:0] One = CW'(1);

  chan_cfg_t     cur_q, cur_d, pend_q, pend_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_cur, div_nxt;
  logic          div_out_q, div_out_d, tick_q, tick_d;
  logic          is_active, wrap, load;

  assign div_cur   = CW'(cur_q.div);
  assign is_active = (div_cur != '0);
  assign wrap      = is_active & ena & (cnt_q == div_cur - One);

  always_comb begin
    cur_d     = cur_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    load      = sync_all;

    if (sync_all || wrap) begin
      cnt_d = '0;
      if (pending_q) begin
        cur_d     = pend_q;
        pending_d = 1'b0;
      end
    end else if (is_active && ena) begin
      cnt_d = cnt_q + One;
    end

    // Evaluated after the boundary so a write on a wrap edge defers a full period.
    if (wr_en) begin
      if (!is_active) begin
        cur_d.div  = MaxCw'(wr_div);
        cur_d.mode = mode_e'(wr_mode);
        cnt_d      = '0;
        load       = 1'b1;
      end else begin
        pend_d.div  = MaxCw'(wr_div);
        pend_d.mode = mode_e'(wr_mode);
        pending_d   = 1'b1;
      end
    end

    div_nxt = CW'(cur_d.div);
    tick_d  = ena & (div_nxt != '0) & (cnt_d == div_nxt - One);

    if (div_nxt == '0) begin
      div_out_d = 1'b0;
    end else if (cur_d.mode == MODE_PULSE) begin
      div_out_d = tick_d;
    end else if (ena || load) begin
      div_out_d = (cnt_d < (div_nxt >> 1));
    end else begin
      div_out_d = div_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q     <= '{div: '0, mode: MODE_SQUARE};
      pend_q    <= '{div: '0, mode: MODE_SQUARE};
      pending_q <= 1'b0;
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;
  assign active  = is_active;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH synchronous clock-enable dividers sharing one config write port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  sync_all,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [CW-1:0]         cfg_div,
  input  logic                  cfg_mode,
  output logic [NCH-1:0]        div_out,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        active
);

  localparam int unsigned ChW = ch_w(NCH);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr_en;
  logic           sel_pending;
  logic           accept;

  // Out-of-range channel indices read as not pending, so they are accepted and dropped.
  always_comb begin
    sel_pending = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch == ChW'(i)) sel_pending = pending[i];
    end
  end

  assign cfg_ready = ~reset & ~sel_pending;
  assign accept    = cfg_valid & cfg_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign wr_en[g] = accept & (cfg_ch == ChW'(g));

    clk_div_chan #(
      .CW(CW)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .ena     (ena),
      .sync_all(sync_all),
      .wr_en   (wr_en[g]),
      .wr_div  (cfg_div),
      .wr_mode (cfg_mode),
      .div_out (div_out[g]),
      .tick    (tick[g]),
      .active  (active[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a reference model feeding a scoreboard queue.
module tb_clk_div_bank;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           reset, ena, sync_all, cfg_valid, cfg_mode;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] div_out, tick, active;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NCH(NCH),
    .CW (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .sync_all (sync_all),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .div_out  (div_out),
    .tick     (tick),
    .active   (active)
  );

  typedef struct packed {
    logic [NCH-1:0] d;
    logic [NCH-1:0] t;
    logic [NCH-1:0] a;
  } exp_t;

  exp_t sb[$];
  exp_t last_obs;
  logic last_rdy;

  int errors = 0;
  int checks = 0;

  int m_div[NCH], m_cnt[NCH], m_pdiv[NCH];
  bit m_mode[NCH], m_pend[NCH], m_pmode[NCH], m_out[NCH];

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check cfg_ready, advance model, push, clock, pop and compare.
  task automatic step(input bit r, input bit e, input bit s, input bit v,
                      input int ch, input int dv, input bit md);
    exp_t ex;
    bit   rdy, acc, act, wrap, load, tk;
    reset = r; ena = e; sync_all = s; cfg_valid = v;
    cfg_ch = ch[1:0]; cfg_div = dv[CW-1:0]; cfg_mode = md;
    #1;
    rdy = !r && !(ch < NCH && m_pend[ch]);
    last_rdy = cfg_ready;
    check1("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
    acc = v && rdy;
    ex = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_div[i] = 0; m_cnt[i] = 0; m_pdiv[i] = 0;
        m_mode[i] = 0; m_pend[i] = 0; m_pmode[i] = 0; m_out[i] = 0;
      end else begin
        act  = (m_div[i] != 0);
        wrap = act && e && (m_cnt[i] == m_div[i] - 1);
        load = s;
        if (s || wrap) begin
          m_cnt[i] = 0;
          if (m_pend[i]) begin
            m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i]; m_pend[i] = 0;
          end
        end else if (act && e) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        if (acc && ch == i) begin
          if (!act) begin
            m_div[i] = dv; m_mode[i] = md; m_cnt[i] = 0; load = 1;
          end else begin
            m_pdiv[i] = dv; m_pmode[i] = md; m_pend[i] = 1;
          end
        end
        tk = e && (m_div[i] != 0) && (m_cnt[i] == m_div[i] - 1);
        if (m_div[i] == 0) m_out[i] = 0;
        else if (m_mode[i]) m_out[i] = tk;
        else if (e || load) m_out[i] = (m_cnt[i] < m_div[i] / 2);
        ex.d[i] = m_out[i];
        ex.t[i] = tk;
        ex.a[i] = (m_div[i] != 0);
      end
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    last_obs = '{d: div_out, t: tick, a: active};
    check1("div_out", {29'd0, div_out}, {29'd0, ex.d});
    check1("tick",    {29'd0, tick},    {29'd0, ex.t});
    check1("active",  {29'd0, active},  {29'd0, ex.a});
  endtask

  task automatic run(input int n, input int ch);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, ch, 0, 0);
  endtask

  task automatic wr(input int ch, input int dv, input bit md);
    step(0, 1, 0, 1, ch, dv, md);
  endtask

  initial begin
    logic [7:0]     pat, tp;
    logic [12:0]    tp1;
    logic [2:0]     rdy_seq;
    logic [NCH-1:0] acc_or;
    logic           d0;

    reset = 1'b1; ena = 1'b0; sync_all = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

    // Reset, then idle: nothing may toggle.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0);
    acc_or = '0;
    for (int k = 0; k < 20; k++) begin
      run(1, 0);
      acc_or = acc_or | last_obs.d | last_obs.t | last_obs.a;
    end
    check1("idle_quiet", {29'd0, acc_or}, 32'd0);
    check1("idle_ready", {31'd0, last_rdy}, 32'd1);

    // ch0 D=4 square: 1100 repeating, tick on the last low cycle.
    pat = '0; tp = '0;
    wr(0, 4, 0);
    pat = {pat[6:0], last_obs.d[0]}; tp = {tp[6:0], last_obs.t[0]};
    for (int k = 0; k < 7; k++) begin
      run(1, 0);
      pat = {pat[6:0], last_obs.d[0]}; tp = {tp[6:0], last_obs.t[0]};
    end
    check1("sq4_pattern", {24'd0, pat}, 32'h000000CC);
    check1("sq4_tick", {24'd0, tp}, 32'h00000011);
    check1("sq4_active", {31'd0, last_obs.a[0]}, 32'd1);

    // ch1 D=3 pulse, then D=5 deferred to the wrap.
    tp1 = '0; rdy_seq = '0;
    wr(1, 3, 1);
    tp1 = {tp1[11:0], last_obs.t[1]};
    wr(1, 5, 1);
    tp1 = {tp1[11:0], last_obs.t[1]};
    for (int k = 0; k < 11; k++) begin
      run(1, 1);
      if (k < 3) rdy_seq = {rdy_seq[1:0], last_rdy};
      tp1 = {tp1[11:0], last_obs.t[1]};
    end
    check1("ch1_ready_hold", {29'd0, rdy_seq}, 32'b001);
    check1("ch1_tick_3to5", {19'd0, tp1}, 32'b0010000100001);

    // ch0 to D=6, then freeze mid-period for 7 cycles.
    wr(0, 6, 0);
    run(10, 0);
    d0 = last_obs.d[0];
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check1("freeze_div", {31'd0, last_obs.d[0]}, {31'd0, d0});
      check1("freeze_tick", {29'd0, last_obs.t}, 32'd0);
    end
    run(8, 0);

    // Channels at 3/4/5, pending on ch2, out-of-range write, then sync_all.
    wr(0, 3, 0);
    wr(1, 4, 0);
    wr(2, 5, 0);
    run(12, 0);
    wr(3, 7, 0);
    check1("oob_ready", {31'd0, last_rdy}, 32'd1);
    wr(2, 2, 0);
    run(1, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    check1("sync_div", {29'd0, last_obs.d}, 32'b111);
    check1("sync_tick", {29'd0, last_obs.t}, 32'd0);
    run(1, 0);
    check1("post_sync_div", {29'd0, last_obs.d}, 32'b010);
    check1("post_sync_tick", {29'd0, last_obs.t}, 32'b100);

    // Disable ch1 at its boundary, then reset over a pending write on ch0.
    wr(1, 0, 0);
    run(5, 0);
    check1("ch1_disabled", {31'd0, last_obs.a[1]}, 32'd0);
    wr(0, 7, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    acc_or = '0;
    for (int k = 0; k < 10; k++) begin
      run(1, 0);
      acc_or = acc_or | last_obs.t | last_obs.a | last_obs.d;
    end
    check1("reset_clears", {29'd0, acc_or}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
